// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer: launches the CPU, gates commits, halts, counts retires.
// Optional PC breakpoint compare: define CPU_RUN_CTRL_BREAKPOINT_EN.
module cpu_run_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             clear_req,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      bp_addr_i,
    input  logic             bp_valid_i,
    output logic             cpu_start_o,
    output logic             cpu_en_o,
    output logic [2:0]       state_o,
    output logic [1:0]       halt_cause_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_STEP   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [31:0] EBREAK    = 32'h0010_0073;
    localparam logic [31:0] SELF_LOOP = 32'h0000_006F;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_mode;
    logic             w_mode_next;
    logic [7:0]       r_cnt;
    logic             r_run_q;
    logic             r_step_q;
    logic             r_halt_q;
    logic             r_resume;
    logic             r_start;
    logic [1:0]       r_cause;
    logic [1:0]       w_cause_next;
    logic [CNT_W-1:0] r_retired;

    logic w_run_edge;
    logic w_step_edge;
    logic w_halt_edge;
    logic w_hit_inst;
    logic w_hit_bp;
    logic w_stop_eff;
    logic w_en;
    logic w_enter_launch;

    assign w_run_edge  = run_req & ~r_run_q;
    assign w_step_edge = step_req & ~r_step_q;
    assign w_halt_edge = halt_req & ~r_halt_q;

    assign w_hit_inst = (inst_i == EBREAK) || (inst_i == SELF_LOOP);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    assign w_hit_bp = bp_valid_i && (pc_i == bp_addr_i);
`else
    logic w_unused_bp;
    assign w_unused_bp = &{1'b0, pc_i, bp_addr_i, bp_valid_i};
    assign w_hit_bp    = 1'b0;
`endif

    // The instruction that stopped us must commit on resume, so mask once.
    assign w_stop_eff = (r_state == S_RUN) && (w_hit_inst || w_hit_bp)
                        && !r_resume;

    assign w_en = ((r_state == S_RUN) && !w_stop_eff && !w_halt_edge
                   && !clear_req)
                  || ((r_state == S_STEP) && !clear_req);

    always_comb begin
        w_next       = r_state;
        w_mode_next  = r_mode;
        w_cause_next = r_cause;
        if (clear_req) begin
            w_next       = S_IDLE;
            w_cause_next = 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_step_edge) begin
                        w_next      = S_LAUNCH;
                        w_mode_next = 1'b1;
                    end else if (w_run_edge) begin
                        w_next      = S_LAUNCH;
                        w_mode_next = 1'b0;
                    end
                    w_cause_next = 2'd0;
                end
                S_LAUNCH: begin
                    if (r_cnt <= 8'd1)
                        w_next = r_mode ? S_HALT : S_RUN;
                end
                S_RUN: begin
                    if (w_stop_eff) begin
                        w_next       = S_HALT;
                        w_cause_next = w_hit_bp ? 2'd3 : 2'd2;
                    end else if (w_halt_edge) begin
                        w_next       = S_HALT;
                        w_cause_next = 2'd1;
                    end
                end
                S_HALT: begin
                    if (w_step_edge) begin
                        w_next       = S_STEP;
                        w_cause_next = 2'd0;
                    end else if (w_run_edge) begin
                        w_next       = S_RUN;
                        w_cause_next = 2'd0;
                    end
                end
                S_STEP: begin
                    w_next       = S_HALT;
                    w_cause_next = 2'd1;
                end
                default: begin
                    w_next       = S_IDLE;
                    w_cause_next = 2'd0;
                end
            endcase
        end
    end

    assign w_enter_launch = (w_next == S_LAUNCH) && (r_state != S_LAUNCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_cnt     <= 8'd0;
            r_run_q   <= 1'b1;
            r_step_q  <= 1'b1;
            r_halt_q  <= 1'b1;
            r_resume  <= 1'b0;
            r_start   <= 1'b0;
            r_cause   <= 2'd0;
            r_retired <= '0;
        end else begin
            r_state  <= w_next;
            r_mode   <= w_mode_next;
            r_run_q  <= run_req;
            r_step_q <= step_req;
            r_halt_q <= halt_req;
            r_resume <= (r_state == S_HALT) && (w_next == S_RUN);
            r_start  <= (w_next == S_RUN) || (w_next == S_STEP)
                        || (w_next == S_HALT);
            r_cause  <= w_cause_next;
            if (w_enter_launch)
                r_cnt <= 8'(RST_CYCLES);
            else if ((r_state == S_LAUNCH) && (r_cnt != 8'd0))
                r_cnt <= r_cnt - 8'd1;
            if (w_enter_launch)
                r_retired <= '0;
            else if (w_en && (r_retired != {CNT_W{1'b1}}))
                r_retired <= r_retired + 1'b1;
        end
    end

    assign cpu_start_o  = r_start;
    assign cpu_en_o     = w_en;
    assign state_o      = r_state;
    assign halt_cause_o = r_cause;
    assign retired_o    = r_retired;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: cycle table plus saturation and breakpoint sequences.
// Breakpoint expectations follow CPU_RUN_CTRL_BREAKPOINT_EN.
module tb_cpu_run_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EB  = 32'h0010_0073;
    localparam logic [31:0] SL  = 32'h0000_006F;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_req, step_req, halt_req, clear_req;
    logic [31:0] pc_i, inst_i, bp_addr_i;
    logic        bp_valid_i;
    logic        cpu_start_o, cpu_en_o;
    logic [2:0]  state_o;
    logic [1:0]  halt_cause_o;
    logic [3:0]  retired_o;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.RST_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .run_req(run_req), .step_req(step_req),
        .halt_req(halt_req), .clear_req(clear_req),
        .pc_i(pc_i), .inst_i(inst_i),
        .bp_addr_i(bp_addr_i), .bp_valid_i(bp_valid_i),
        .cpu_start_o(cpu_start_o), .cpu_en_o(cpu_en_o),
        .state_o(state_o), .halt_cause_o(halt_cause_o),
        .retired_o(retired_o)
    );

    typedef struct {
        logic        run, step, halt, clr;
        logic [31:0] pc, inst;
        logic [2:0]  st;
        logic        start, en;
        logic [1:0]  cause;
        logic [3:0]  ret;
    } vec_t;

    vec_t tv[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic h,
                       input logic c, input logic [31:0] pc,
                       input logic [31:0] ins, input logic [2:0] st,
                       input logic start, input logic en,
                       input logic [1:0] cause, input logic [3:0] ret);
        vec_t v;
        v.run = r; v.step = s; v.halt = h; v.clr = c;
        v.pc = pc; v.inst = ins; v.st = st; v.start = start;
        v.en = en; v.cause = cause; v.ret = ret;
        tv.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pc;
        int          k;
        // run, step, halt, clr, pc, inst | state, start, en, cause, ret
        add(1,0,0,0, 32'h0,  NOP, 0,0,0,0,0);
        add(0,0,0,0, 32'h0,  NOP, 0,0,0,0,0);
        add(1,0,0,0, 32'h0,  NOP, 0,0,0,0,0);
        for (int i = 0; i < 4; i++)
            add(1,0,0,0, 32'h0, NOP, 1,0,0,0,0);
        add(1,0,0,0, 32'h0,  NOP, 2,1,1,0,0);
        add(1,0,0,0, 32'h4,  NOP, 2,1,1,0,1);
        add(1,0,0,0, 32'h8,  NOP, 2,1,1,0,2);
        add(1,0,0,0, 32'hC,  NOP, 2,1,1,0,3);
        add(1,0,0,0, 32'h10, EB,  2,1,0,0,4);
        add(0,0,0,0, 32'h10, EB,  4,1,0,2,4);
        add(0,1,0,0, 32'h10, EB,  4,1,0,2,4);
        add(0,1,0,0, 32'h10, EB,  3,1,1,0,4);
        add(0,0,0,0, 32'h10, EB,  4,1,0,1,5);
        add(0,1,0,0, 32'h10, EB,  4,1,0,1,5);
        add(0,0,0,0, 32'h10, EB,  3,1,1,0,5);
        add(0,1,0,0, 32'h10, EB,  4,1,0,1,6);
        add(0,0,0,0, 32'h10, EB,  3,1,1,0,6);
        add(0,0,0,0, 32'h10, EB,  4,1,0,1,7);
        add(1,0,0,0, 32'h10, EB,  4,1,0,1,7);
        add(0,0,0,0, 32'h10, EB,  2,1,1,0,7);
        add(0,0,1,0, 32'h14, EB,  2,1,0,0,8);
        add(0,0,1,0, 32'h14, NOP, 4,1,0,2,8);
        add(1,0,0,0, 32'h14, NOP, 4,1,0,2,8);
        add(1,0,0,0, 32'h14, NOP, 2,1,1,0,8);
        add(0,0,1,0, 32'h18, NOP, 2,1,0,0,9);
        add(0,0,0,0, 32'h18, NOP, 4,1,0,1,9);
        add(1,0,0,0, 32'h18, NOP, 4,1,0,1,9);
        add(0,0,0,0, 32'h18, NOP, 2,1,1,0,9);
        add(0,0,0,1, 32'h1C, NOP, 2,1,0,0,10);
        add(0,0,0,0, 32'h0,  NOP, 0,0,0,0,10);
        add(0,0,0,0, 32'h0,  NOP, 0,0,0,0,10);
        add(1,0,0,0, 32'h0,  NOP, 0,0,0,0,10);
        add(0,0,0,0, 32'h0,  NOP, 1,0,0,0,0);
        add(0,0,0,1, 32'h0,  NOP, 1,0,0,0,0);
        add(0,0,0,0, 32'h0,  NOP, 0,0,0,0,0);
        add(1,1,0,0, 32'h0,  NOP, 0,0,0,0,0);
        for (int i = 0; i < 4; i++)
            add(0,0,0,0, 32'h0, NOP, 1,0,0,0,0);
        add(0,0,0,0, 32'h0,  NOP, 4,1,0,0,0);

        rst = 1'b1; run_req = 1'b1; step_req = 1'b0; halt_req = 1'b0;
        clear_req = 1'b0; pc_i = '0; inst_i = NOP;
        bp_addr_i = 32'h8; bp_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.state", 32'(state_o), 0);
        chk("rst.start", 32'(cpu_start_o), 0);
        chk("rst.en", 32'(cpu_en_o), 0);
        chk("rst.cause", 32'(halt_cause_o), 0);
        chk("rst.ret", 32'(retired_o), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tv[i]) begin
            run_req = tv[i].run; step_req = tv[i].step;
            halt_req = tv[i].halt; clear_req = tv[i].clr;
            pc_i = tv[i].pc; inst_i = tv[i].inst;
            #1;
            chk($sformatf("v%0d.state", i), 32'(state_o), 32'(tv[i].st));
            chk($sformatf("v%0d.start", i), 32'(cpu_start_o),
                32'(tv[i].start));
            chk($sformatf("v%0d.en", i), 32'(cpu_en_o), 32'(tv[i].en));
            chk($sformatf("v%0d.cause", i), 32'(halt_cause_o),
                32'(tv[i].cause));
            chk($sformatf("v%0d.ret", i), 32'(retired_o), 32'(tv[i].ret));
            @(negedge clk);
        end

        // Saturation then self-loop stall
        run_req = 1'b1; step_req = 1'b0; pc_i = '0; inst_i = NOP;
        @(negedge clk);
        run_req = 1'b0;
        #1;
        chk("sat.run", 32'(state_o), 2);
        for (int i = 0; i < 16; i++) begin
            pc_i = 32'(i * 4);
            @(negedge clk);
        end
        #1;
        chk("sat.ret", 32'(retired_o), 15);
        chk("sat.state", 32'(state_o), 2);
        pc_i = 32'h20; inst_i = SL;
        #1;
        chk("loop.en", 32'(cpu_en_o), 0);
        @(negedge clk);
        #1;
        chk("loop.state", 32'(state_o), 4);
        chk("loop.cause", 32'(halt_cause_o), 2);
        chk("loop.ret", 32'(retired_o), 15);

        // Clear from HALT, then breakpoint run
        @(negedge clk);
        clear_req = 1'b1; inst_i = NOP;
        @(negedge clk);
        clear_req = 1'b0;
        #1;
        chk("clr.state", 32'(state_o), 0);
        chk("clr.start", 32'(cpu_start_o), 0);
        pc = '0; pc_i = '0; bp_valid_i = 1'b1; bp_addr_i = 32'h8;
        run_req = 1'b1;
        @(negedge clk);
        run_req = 1'b0;
        k = 0;
        #1;
        while (state_o != 3'd2 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("bp.launch_bound", 32'(k < 20), 1);
        for (int i = 0; i < 10; i++) begin
            pc_i = pc;
            #1;
            if (state_o == 3'd4) break;
            if (cpu_en_o) pc = pc + 32'd4;
            @(negedge clk);
        end
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        chk("bp.state", 32'(state_o), 4);
        chk("bp.cause", 32'(halt_cause_o), 3);
        chk("bp.pc", pc, 32'h8);
        chk("bp.ret", 32'(retired_o), 2);
        run_req = 1'b1;
        @(negedge clk);
        run_req = 1'b0;
        #1;
        chk("bp.resume_state", 32'(state_o), 2);
        chk("bp.resume_en", 32'(cpu_en_o), 1);
        @(negedge clk);
        #1;
        chk("bp.resume_ret", 32'(retired_o), 3);
`else
        #1;
        chk("nobp.state", 32'(state_o), 2);
        chk("nobp.pc", pc, 32'd40);
        chk("nobp.ret", 32'(retired_o), 10);
        chk("nobp.cause", 32'(halt_cause_o), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
